// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Brief    : 640x480@60 raster constants and shared painter colours.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int unsigned PIX_DIV_DEF = 4;

  localparam int unsigned H_SYNC_LEN  = 96;
  localparam int unsigned H_BACK_LEN  = 48;
  localparam int unsigned H_VIS_LEN   = 640;
  localparam int unsigned H_FRONT_LEN = 16;

  localparam int unsigned V_SYNC_LEN  = 2;
  localparam int unsigned V_BACK_LEN  = 33;
  localparam int unsigned V_VIS_LEN   = 480;
  localparam int unsigned V_FRONT_LEN = 10;

  localparam int unsigned H_TOTAL     = H_SYNC_LEN + H_BACK_LEN + H_VIS_LEN + H_FRONT_LEN;
  localparam int unsigned V_TOTAL     = V_SYNC_LEN + V_BACK_LEN + V_VIS_LEN + V_FRONT_LEN;
  localparam int unsigned H_VIS_START = H_SYNC_LEN + H_BACK_LEN;
  localparam int unsigned V_VIS_START = V_SYNC_LEN + V_BACK_LEN;

  // Colours are {R[3:0], G[3:0], B[3:0]}
  typedef logic [11:0] rgb12_t;

  localparam rgb12_t BLACK   = 12'h000;
  localparam rgb12_t WHITE   = 12'hFFF;
  localparam rgb12_t RED     = 12'hF00;
  localparam rgb12_t GREEN   = 12'h0F0;
  localparam rgb12_t BLUE    = 12'h00F;
  localparam rgb12_t YELLOW  = 12'hFF0;
  localparam rgb12_t CYAN    = 12'h0FF;
  localparam rgb12_t MAGENTA = 12'hF0F;

endpackage
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_div
// Brief    : Board-clock divider producing a one-clk pixel strobe.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV = PIX_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int unsigned            c_div_w    = $clog2(PIX_DIV);
  localparam logic [c_div_w-1:0]     c_div_last = c_div_w'(PIX_DIV - 1);

  logic [c_div_w-1:0] r_div;

  // Explicit wrap so non-power-of-two ratios stay exact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == c_div_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign pix_tick = (r_div == c_div_last);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster counters, visible-window decode and registered
//            sync/colour output stage with a once-per-frame strobe.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV = PIX_DIV_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_LEN,
  parameter int unsigned H_BACK  = H_BACK_LEN,
  parameter int unsigned H_VIS   = H_VIS_LEN,
  parameter int unsigned H_FRONT = H_FRONT_LEN,
  parameter int unsigned V_SYNC  = V_SYNC_LEN,
  parameter int unsigned V_BACK  = V_BACK_LEN,
  parameter int unsigned V_VIS   = V_VIS_LEN,
  parameter int unsigned V_FRONT = V_FRONT_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic        pix_tick,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam logic [9:0] c_h_last    = 10'(H_SYNC + H_BACK + H_VIS + H_FRONT - 1);
  localparam logic [9:0] c_v_last    = 10'(V_SYNC + V_BACK + V_VIS + V_FRONT - 1);
  localparam logic [9:0] c_h_sync    = 10'(H_SYNC);
  localparam logic [9:0] c_v_sync    = 10'(V_SYNC);
  localparam logic [9:0] c_h_vis_beg = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] c_h_vis_end = 10'(H_SYNC + H_BACK + H_VIS - 1);
  localparam logic [9:0] c_v_vis_beg = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] c_v_vis_end = 10'(V_SYNC + V_BACK + V_VIS - 1);

  logic        w_pix_tick;
  logic        w_bright;
  logic        w_frame_tick;
  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_rgb;

  vga_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (w_pix_tick)
  );

  assign w_bright = (r_hcount >= c_h_vis_beg) && (r_hcount <= c_h_vis_end) &&
                    (r_vcount >= c_v_vis_beg) && (r_vcount <= c_v_vis_end);

  // Last pixel of the last visible line: the edge that enters vertical blanking
  assign w_frame_tick = w_pix_tick && (r_hcount == c_h_last) && (r_vcount == c_v_vis_end);

  // Output stage samples the pre-increment coordinates, so sync and colour
  // leave together one pixel behind hCount/vCount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_rgb    <= '0;
    end else if (w_pix_tick) begin
      r_hsync <= (r_hcount >= c_h_sync);
      r_vsync <= (r_vcount >= c_v_sync);
      r_rgb   <= w_bright ? rgb_in : 12'h000;
      if (r_hcount == c_h_last) begin
        r_hcount <= '0;
        r_vcount <= (r_vcount == c_v_last) ? 10'd0 : r_vcount + 10'd1;
      end else begin
        r_hcount <= r_hcount + 10'd1;
      end
    end
  end

  assign pix_tick   = w_pix_tick;
  assign hCount     = r_hcount;
  assign vCount     = r_vcount;
  assign bright     = w_bright;
  assign frame_tick = w_frame_tick;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign vga_r      = r_rgb[11:8];
  assign vga_g      = r_rgb[7:4];
  assign vga_b      = r_rgb[3:0];

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the 640x480 at 60 Hz VGA raster that every pixel-painting controller in the design consumes.
- Divides the board clock into a pixel tick and produces the `hCount`/`vCount`/`bright` scan coordinates.
- Registers the painter's combinational `rgb` together with the sync pulses, so colour and sync leave the FPGA aligned.
- Emits a once-per-frame pulse that game logic uses as its slow update strobe.

## Interface
- `PIX_DIV`, 4: board clocks per pixel (100 MHz to 25 MHz); legal values 2..16.
- `H_SYNC`, 96; `H_BACK`, 48; `H_VIS`, 640; `H_FRONT`, 16: horizontal segment lengths in pixels (total 800).
- `V_SYNC`, 2; `V_BACK`, 33; `V_VIS`, 480; `V_FRONT`, 10: vertical segment lengths in lines (total 525).
- `clk`  in  1: board clock, 100 MHz.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `rgb_in`  in  12: painter colour for the current `hCount`/`vCount`, ordered {R[3:0], G[3:0], B[3:0]}.
- `pix_tick`  out  1: one-`clk` strobe, once per pixel.
- `hCount`  out  10: current column, 0..799.
- `vCount`  out  10: current line, 0..524.
- `bright`  out  1: high when the current pixel is inside the visible window.
- `frame_tick`  out  1: one-`clk` strobe at the start of vertical blanking.
- `hSync`  out  1: horizontal sync to the connector, active-low, registered.
- `vSync`  out  1: vertical sync to the connector, active-low, registered.
- `vga_r`  out  4: red output to the connector, registered.
- `vga_g`  out  4: green output to the connector, registered.
- `vga_b`  out  4: blue output to the connector, registered.

## Operation
**Pixel divider**
- `div` counts 0..`PIX_DIV`-1 and wraps.
- `pix_tick` = (`div` == `PIX_DIV`-1).

**Counters**
- Both counters advance only on a `clk` edge where `pix_tick` is high.
- `hCount` increments; at 799 it wraps to 0.
- `vCount` increments when `hCount` wraps; at 524 it wraps to 0.

**Segment order**
- Each axis runs sync, then back porch, then visible, then front porch.
- Horizontal: sync is `hCount` 0..95, visible is 144..783.
- Vertical: sync is `vCount` 0..1, visible is 35..514.

**Current-pixel signals**
- `bright` is combinational from the registered counters: (144 ≤ `hCount` ≤ 783) and (35 ≤ `vCount` ≤ 514).

**Output stage** (updates on each `pix_tick` edge)
- `hSync` ← ¬(`hCount` < `H_SYNC`).
- `vSync` ← ¬(`vCount` < `V_SYNC`).
- {`vga_r`,`vga_g`,`vga_b`} ← `bright` ? `rgb_in` : 0.
- Every value is sampled from the pre-increment counters, so all connector outputs lag the coordinates by exactly one pixel.
- Blanking is forced to 0 here, whatever `rgb_in` holds.

**Frame tick**
- `frame_tick` = `pix_tick` and (`hCount` == 799) and (`vCount` == 514).
- It therefore coincides with the edge that moves the counters to (0, 515).

**Boundaries**
- The frame wrap (799,524) → (0,0) happens on a single tick.
- `hSync` and `vSync` may both assert on the same tick.
- Reset deasserting mid-frame restarts the raster from (0,0).

## Timing
**Reset values** (reset is asynchronous and applies immediately)
- `div` = 0, `hCount` = 0, `vCount` = 0.
- `hSync` = 1, `vSync` = 1.
- `vga_r`, `vga_g`, `vga_b` = 0.
- `pix_tick` = 0, `frame_tick` = 0.
- `bright` = 0, because (0,0) is outside the visible window.

**After reset release** (cycle 1 is the first `clk` edge with `rst_n` high)
- `div` takes the values 0,1,2,3 on cycles 1..4.
- The first `pix_tick` is high during cycle 4. On that edge the counters move to (1,0) and `hSync`/`vSync` go low, because they sample (0,0).

**Rates and widths**
- Line period: 800 × `PIX_DIV` clocks.
- Frame period: 420 000 pixels, which is 1 680 000 clocks at `PIX_DIV` = 4.
- `frame_tick` period equals the frame period. It never lasts more than one `clk`.
- `rgb_in` must settle within one `PIX_DIV` window after the counters change. The painter is purely combinational on `hCount`/`vCount`.

## Structure
- Shared package `vga_pkg` holds:
  - the eight segment-length constants;
  - the derived `H_TOTAL` (800), `V_TOTAL` (525), `H_VIS_START` (144) and `V_VIS_START` (35);
  - the 12-bit colour constants the painters share (`RED`, `WHITE`, `BLACK`, ...).
- One natural sub-module, `vga_pix_div`: the parameterised divider producing `pix_tick`.
- Counters, decode and output registers stay in the top level.

## Test plan
- **Reset mid-frame.** Pulse `rst_n` low for 3 clocks while `vCount` = 300. → Outputs take reset values immediately. First `pix_tick` is 4 clocks after release. Counters then run (1,0), (2,0), ...
- **Horizontal timing.** Run one line. → `hCount` sequence 0..799 then 0. `hSync` is low for exactly 96 pixel ticks, lagging `hCount` by 1 pixel. `bright` is high for exactly 640 consecutive pixels starting at `hCount` = 144.
- **Vertical timing.** Run two full frames. → `vCount` wraps 524 → 0. `vSync` is low for 2 lines. There are 480 lines containing `bright`. `frame_tick` appears exactly once per 1 680 000 clocks, on the edge to (0, 515).
- **Colour gating.** Hold `rgb_in` = 12'hF0F constant. → `vga_*` = F,0,F one tick after each visible pixel. It is 0 one tick after `hCount` 143 and 784, and throughout `vCount` 0..34 and 515..524.
- **Pipeline alignment.** Drive `rgb_in` = {2'b0, `hCount`} (10 bits zero-extended to 12). → On every tick the registered colour equals the previous `hCount`, aligned with `hSync` as registered from that same `hCount`.
- **Non-default divider.** `PIX_DIV` = 2. → `pix_tick` every 2 clocks. Frame period 840 000 clocks. All segment counts unchanged.
